// File: rtl/cpu_pkg.sv
// Shared types for the memory-port arbiter: read-response owner encoding and
// response-tracker states.
package cpu_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        DBG   = 2'd3
    } mem_owner_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } rsp_state_t;

    localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and read-response signals around the arbiter.
// The master side drives requests and memory read data; the slave side is the arbiter.
interface mem_port_arbiter_if;
    import cpu_pkg::*;

    logic        fetch_req;
    logic [29:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_stall;

    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;

    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;

    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        rsp_valid;
    mem_owner_t  rsp_owner;
    logic [31:0] rsp_rdata;

    modport master (
        output fetch_req, fetch_addr,
        output data_req, data_we, data_addr, data_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  fetch_gnt, fetch_stall, data_gnt, dbg_gnt,
        input  mem_addr, mem_we, mem_wdata,
        input  rsp_valid, rsp_owner, rsp_rdata
    );

    modport slave (
        input  fetch_req, fetch_addr,
        input  data_req, data_we, data_addr, data_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output fetch_gnt, fetch_stall, data_gnt, dbg_gnt,
        output mem_addr, mem_we, mem_wdata,
        output rsp_valid, rsp_owner, rsp_rdata
    );

endinterface

// File: rtl/rr_starve_counter.sv
// Counts enabled cycles in which a pending debug request was denied; once the
// count reaches LIMIT the debug port is forced to win the next arbitration.
module rr_starve_counter
    import cpu_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic dbg_req,
    input  logic dbg_gnt,
    output logic force_dbg
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_W = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_reg;
    logic [STARVE_CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (!dbg_req || dbg_gnt) begin
            cnt_next = '0;
        end else if (cnt_reg != LIMIT_W) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_next;
        end
    end

    assign force_dbg = (cnt_reg == LIMIT_W);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch, data and debug requesters, with a
// response tracker that steers the one-cycle-late read data to its owner.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_enable,
    mem_port_arbiter_if.slave  bus
);

    mem_owner_t  win;
    logic        force_dbg;
    logic        dbg_gnt;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic        rd_issue;
    logic [31:0] addr_hold_reg;
    logic [31:0] wdata_hold_reg;
    rsp_state_t  state_reg;
    rsp_state_t  state_next;
    mem_owner_t  owner_reg;
    mem_owner_t  owner_next;

    rr_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (clk_enable),
        .dbg_req   (bus.dbg_req),
        .dbg_gnt   (dbg_gnt),
        .force_dbg (force_dbg)
    );

    always_comb begin
        win = NONE;
        if (clk_enable) begin
            if (force_dbg && bus.dbg_req) begin
                win = DBG;
            end else if (bus.data_req) begin
                win = DATA;
            end else if (bus.fetch_req) begin
                win = FETCH;
            end else if (bus.dbg_req) begin
                win = DBG;
            end
        end
    end

    assign dbg_gnt         = (win == DBG);
    assign bus.dbg_gnt     = dbg_gnt;
    assign bus.data_gnt    = (win == DATA);
    assign bus.fetch_gnt   = (win == FETCH);
    assign bus.fetch_stall = bus.fetch_req && (win != FETCH);

    // With no winner the address/data lines park on the last granted values.
    always_comb begin
        sel_addr  = addr_hold_reg;
        sel_wdata = wdata_hold_reg;
        sel_we    = 1'b0;
        case (win)
            FETCH: sel_addr = {bus.fetch_addr, 2'b00};
            DATA: begin
                sel_addr  = bus.data_addr;
                sel_wdata = bus.data_wdata;
                sel_we    = bus.data_we;
            end
            DBG: begin
                sel_addr  = bus.dbg_addr;
                sel_wdata = bus.dbg_wdata;
                sel_we    = bus.dbg_we;
            end
            default: ;
        endcase
    end

    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;
    assign bus.mem_we    = sel_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hold_reg  <= '0;
            wdata_hold_reg <= '0;
        end else if (clk_enable && (win != NONE)) begin
            addr_hold_reg  <= sel_addr;
            wdata_hold_reg <= sel_wdata;
        end
    end

    assign rd_issue = (win != NONE) && !sel_we;

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        if (state_reg == IDLE) begin
            if (rd_issue) begin
                state_next = PEND;
                owner_next = win;
            end
        end else begin
            // A back-to-back read re-arms PEND with the new owner.
            if (rd_issue) begin
                owner_next = win;
            end else begin
                state_next = IDLE;
                owner_next = NONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            owner_reg <= NONE;
        end else if (clk_enable) begin
            state_reg <= state_next;
            owner_reg <= owner_next;
        end
    end

    assign bus.rsp_valid = (state_reg == PEND);
    assign bus.rsp_owner = (state_reg == PEND) ? owner_reg : NONE;
    assign bus.rsp_rdata = (state_reg == PEND) ? bus.mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a behavioural arbitration/memory model
// queues expected read responses, and an independent monitor checks them.
module tb_mem_port_arbiter;
    import cpu_pkg::*;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_enable = 1'b0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_enable (clk_enable),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        mem_owner_t  owner;
        logic [31:0] rdata;
    } rsp_t;

    int          n_vec = 0;
    int          n_err = 0;
    rsp_t        exp_q[$];
    logic [31:0] dev_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int          ref_starve = 0;
    logic [31:0] ref_hold_addr = 32'h0;
    logic [31:0] next_rdata = 32'h0;
    mem_owner_t  last_gnt = NONE;
    logic        obs_dbg;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] seed_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] dev_rd(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : seed_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : seed_word(a);
    endfunction

    // One base-clock cycle: check arbitration at the negedge, then commit the
    // model and the memory device on the following posedge.
    task automatic step();
        mem_owner_t  w;
        logic [31:0] a, wd, cap_addr, cap_wdata;
        logic        we, cap_we;
        @(negedge clk);
        w = NONE;
        if (clk_enable) begin
            if (bus.dbg_req && ref_starve == LIMIT) w = DBG;
            else if (bus.data_req)                  w = DATA;
            else if (bus.fetch_req)                 w = FETCH;
            else if (bus.dbg_req)                   w = DBG;
        end
        a  = ref_hold_addr;
        we = 1'b0;
        wd = 32'h0;
        if (w == FETCH) a = {bus.fetch_addr, 2'b00};
        if (w == DATA) begin a = bus.data_addr; we = bus.data_we; wd = bus.data_wdata; end
        if (w == DBG)  begin a = bus.dbg_addr;  we = bus.dbg_we;  wd = bus.dbg_wdata;  end
        chk("grants", {29'b0, bus.fetch_gnt, bus.data_gnt, bus.dbg_gnt},
            {29'b0, w == FETCH, w == DATA, w == DBG});
        chk("fetch_stall", 32'(bus.fetch_stall), 32'(bus.fetch_req && w != FETCH));
        chk("mem_we", 32'(bus.mem_we), 32'(we));
        chk("mem_addr", bus.mem_addr, a);
        if (we) chk("mem_wdata", bus.mem_wdata, wd);
        cap_addr  = bus.mem_addr;
        cap_we    = bus.mem_we;
        cap_wdata = bus.mem_wdata;
        obs_dbg   = bus.dbg_gnt;
        obs_addr  = bus.mem_addr;
        obs_wdata = bus.mem_wdata;
        @(posedge clk);
        last_gnt = NONE;
        if (clk_enable && rst_n) begin
            if (cap_we) dev_mem[cap_addr] = cap_wdata;
            else        next_rdata = dev_rd(cap_addr);
            if (w != NONE) ref_hold_addr = a;
            if (w != NONE && !we) exp_q.push_back(rsp_t'{w, ref_rd(a)});
            if (we) ref_mem[a] = wd;
            if (!bus.dbg_req || w == DBG) ref_starve = 0;
            else if (ref_starve < LIMIT)  ref_starve++;
            last_gnt = w;
        end
        #1 bus.mem_rdata = next_rdata;
    endtask

    task automatic new_reqs();
        if (!bus.fetch_req || last_gnt == FETCH) begin
            bus.fetch_req  = ($urandom_range(0, 99) < 50);
            bus.fetch_addr = 30'($urandom_range(0, 63));
        end
        if (!bus.data_req || last_gnt == DATA) begin
            bus.data_req   = ($urandom_range(0, 99) < 40);
            bus.data_we    = ($urandom_range(0, 2) == 0);
            bus.data_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            bus.data_wdata = $urandom;
        end
        if (!bus.dbg_req || last_gnt == DBG) begin
            bus.dbg_req   = ($urandom_range(0, 99) < 20);
            bus.dbg_we    = ($urandom_range(0, 2) == 0);
            bus.dbg_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            bus.dbg_wdata = $urandom;
        end
        clk_enable = ($urandom_range(0, 4) != 0);
    endtask

    // Response monitor: one expected entry per enabled cycle with a response.
    always @(negedge clk) begin
        if (rst_n && clk_enable) begin
            if (exp_q.size() != 0) begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
                chk("rsp_owner", 32'(bus.rsp_owner), 32'(e.owner));
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
            end else begin
                chk("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
                chk("rsp_owner_idle", 32'(bus.rsp_owner), 32'(NONE));
                chk("rsp_rdata_idle", bus.rsp_rdata, 32'h0);
            end
        end
    end

    initial begin
        int n;
        bus.fetch_req = 1'b0; bus.fetch_addr = '0;
        bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_addr = '0; bus.data_wdata = '0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        bus.mem_rdata = '0;

        // Reset state, and grants still combinational while in reset.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_owner", 32'(bus.rsp_owner), 32'(NONE));
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        bus.fetch_req = 1'b1;
        #1;
        chk("rst_gnt_gated", 32'(bus.fetch_gnt), 32'd0);
        clk_enable = 1'b1;
        #1;
        chk("rst_gnt_comb", 32'(bus.fetch_gnt), 32'd1);
        bus.fetch_req = 1'b0;
        clk_enable = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single fetch read of word 0x10.
        clk_enable = 1'b1;
        bus.fetch_req = 1'b1; bus.fetch_addr = 30'h10;
        step();
        chk("fetch_byte_addr", obs_addr, 32'h40);
        bus.fetch_req = 1'b0;
        step();

        // Data beats fetch, then fetch follows back-to-back.
        bus.fetch_req = 1'b1; bus.fetch_addr = 30'h3;
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h100;
        step();
        chk("data_wins_addr", obs_addr, 32'h100);
        bus.data_req = 1'b0;
        step();
        bus.fetch_req = 1'b0;
        step();

        // Data write, then read it back through the debug port.
        bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_addr = 32'h20; bus.data_wdata = 32'hDEADBEEF;
        step();
        chk("write_wdata", obs_wdata, 32'hDEADBEEF);
        bus.data_req = 1'b0;
        step();
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h20;
        step();
        bus.dbg_req = 1'b0;
        step();

        // Debug starved by continuous data reads wins on the LIMIT+1-th cycle.
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h200;
        bus.data_req = 1'b1; bus.data_we = 1'b0;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            bus.data_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            step();
            if (obs_dbg) begin
                n = i;
                break;
            end
        end
        chk("starve_win_cycle", 32'(n), 32'(LIMIT + 1));
        bus.dbg_req = 1'b0; bus.data_req = 1'b0;
        step();

        // Reset pulse while a read response is pending.
        bus.fetch_req = 1'b1; bus.fetch_addr = 30'h7;
        step();
        bus.fetch_req = 1'b0;
        #2 rst_n = 1'b0;
        exp_q.delete();
        ref_starve = 0;
        ref_hold_addr = 32'h0;
        last_gnt = NONE;
        #1;
        chk("rst_pend_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_pend_owner", 32'(bus.rsp_owner), 32'(NONE));
        chk("rst_pend_addr", bus.mem_addr, 32'h0);
        rst_n = 1'b1;
        step();
        step();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            new_reqs();
            step();
        end

        bus.fetch_req = 1'b0; bus.data_req = 1'b0; bus.dbg_req = 1'b0;
        clk_enable = 1'b1;
        repeat (3) step();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
